// File: rtl/sha_nonce_search.sv
// Nonce search controller around sha_256: sweeps {prefix, nonce} until hash < target.
// Optional SHA_TIMEOUT_EN adds a per-hash watchdog that aborts a stalled core.
module sha_nonce_search #(
    parameter int unsigned MSG_SIZE       = 24,
    parameter int unsigned NONCE_WIDTH    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [MSG_SIZE-NONCE_WIDTH-1:0] prefix,
    input  logic [255:0]                  target,
    output logic [MSG_SIZE-1:0]           sha_message,
    output logic                          sha_enable,
    input  logic [255:0]                  sha_hashed,
    input  logic                          sha_done,
    output logic                          busy,
    output logic                          found,
    output logic                          exhausted,
    output logic [NONCE_WIDTH-1:0]        result_nonce,
    output logic [255:0]                  result_hash,
    output logic [NONCE_WIDTH:0]          attempts,
    output logic                          timeout_err
);
    localparam int unsigned PREFIX_WIDTH = MSG_SIZE - NONCE_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_CHECK, S_FOUND, S_EXHAUSTED
    } state_t;

    state_t                  state, next_state;
    logic [PREFIX_WIDTH-1:0] prefix_q;
    logic [255:0]            target_q;
    logic [255:0]            hash_q;
    logic [NONCE_WIDTH-1:0]  nonce;
    logic                    accept;
    logic                    capture;
    logic                    hit;
    logic                    last_nonce;
    logic                    timed_out;

    assign accept      = start && (state == S_IDLE || state == S_FOUND || state == S_EXHAUSTED);
    assign hit         = hash_q < target_q;
    assign last_nonce  = &nonce;
    assign sha_message = {prefix_q, nonce};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        sha_enable = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE, S_FOUND, S_EXHAUSTED: begin
                if (start)                        next_state = S_LAUNCH;
                else if (abort && state != S_IDLE) next_state = S_IDLE;
            end
            S_LAUNCH: begin
                sha_enable = 1'b1;
                busy       = 1'b1;
                next_state = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                sha_enable = 1'b1;
                busy       = 1'b1;
                if (abort) begin
                    next_state = S_IDLE;
                end else if (sha_done) begin
                    capture    = 1'b1;
                    next_state = S_CHECK;
                end else if (timed_out) begin
                    next_state = S_IDLE;
                end
            end
            S_CHECK: begin
                busy = 1'b1;
                if (abort)           next_state = S_IDLE;
                else if (hit)        next_state = S_FOUND;
                else if (last_nonce) next_state = S_EXHAUSTED;
                else                 next_state = S_LAUNCH;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prefix_q     <= '0;
            target_q     <= '0;
            hash_q       <= '0;
            nonce        <= '0;
            attempts     <= '0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            result_nonce <= '0;
            result_hash  <= '0;
        end else begin
            if (accept) begin
                prefix_q     <= prefix;
                target_q     <= target;
                nonce        <= '0;
                attempts     <= '0;
                found        <= 1'b0;
                exhausted    <= 1'b0;
                result_nonce <= '0;
                result_hash  <= '0;
            end
            if (capture) begin
                hash_q   <= sha_hashed;
                attempts <= attempts + 1'b1;
            end
            // nonce saturates at all-ones; exhaustion is flagged instead of wrapping
            if (state == S_CHECK && !abort) begin
                if (hit) begin
                    result_nonce <= nonce;
                    result_hash  <= hash_q;
                    found        <= 1'b1;
                end else if (last_nonce) begin
                    exhausted <= 1'b1;
                end else begin
                    nonce <= nonce + 1'b1;
                end
            end
        end
    end

`ifdef SHA_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    assign timed_out   = (state == S_WAIT) && (wait_cnt == CNT_LAST);
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) timeout_q <= 1'b0;
            if (state == S_LAUNCH)    wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
            if (timed_out && !abort && !sha_done) timeout_q <= 1'b1;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sha_nonce_search.sv
// Self-checking bench for sha_nonce_search with a 3-cycle behavioural core model.
module tb_sha_nonce_search;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [15:0]  prefix;
    logic [255:0] target;
    logic [23:0]  sha_message;
    logic         sha_enable;
    logic [255:0] sha_hashed;
    logic         sha_done;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic [7:0]   result_nonce;
    logic [255:0] result_hash;
    logic [8:0]   attempts;
    logic         timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [255:0] ALL1 = '1;

    sha_nonce_search #(.MSG_SIZE(24), .NONCE_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .prefix(prefix), .target(target),
        .sha_message(sha_message), .sha_enable(sha_enable),
        .sha_hashed(sha_hashed), .sha_done(sha_done),
        .busy(busy), .found(found), .exhausted(exhausted),
        .result_nonce(result_nonce), .result_hash(result_hash),
        .attempts(attempts), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // behavioural core: done in the 4th consecutive enabled cycle, hash looked up per nonce
    logic [255:0] hash_tab [256];
    logic         core_stall = 1'b0;
    int unsigned  core_cnt = 0;
    always @(posedge clk) core_cnt <= sha_enable ? core_cnt + 1 : 0;
    assign sha_done   = sha_enable && !core_stall && (core_cnt == 3);
    assign sha_hashed = hash_tab[sha_message[7:0]];

    logic [23:0] last_msg = '0;
    always @(negedge clk) if (sha_enable) last_msg <= sha_message;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // reference: linear scan of the hash table for the first value strictly below target
    task automatic ref_search(input logic [255:0] t, output logic f, output logic e,
                              output logic [7:0] n, output logic [8:0] a, output logic [255:0] h);
        f = 1'b0; e = 1'b0; n = '0; a = '0; h = '0;
        for (int i = 0; i < 256; i++) begin
            if (!f) begin
                a = a + 9'd1;
                if (hash_tab[i] < t) begin
                    f = 1'b1;
                    n = 8'(i);
                    h = hash_tab[i];
                end
            end
        end
        e = !f;
    endtask

    task automatic pulse_start(input logic [15:0] p, input logic [255:0] t);
        prefix = p;
        target = t;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic run_search(input logic [15:0] p, input logic [255:0] t,
                              input logic ef, input logic ee, input logic [7:0] en,
                              input logic [8:0] ea, input logic [255:0] eh);
        int n;
        pulse_start(p, t);
        check("launch_enable", sha_enable, 1);
        check("launch_busy", busy, 1);
        check("launch_msg", sha_message, {p, 8'h00});
        n = 0;
        while (!(found || exhausted) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("search_bound", n < 2000, 1);
        check("found", found, ef);
        check("exhausted", exhausted, ee);
        check("result_nonce", result_nonce, en);
        check("result_hash", result_hash, eh);
        check("attempts", attempts, ea);
        check("busy_end", busy, 0);
        check("final_msg", last_msg, {p, ee ? 8'hFF : en});
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0]  prefix;
        logic [255:0] target;
        int           hit_at;
        int           eq_at;
        logic         exp_found;
        logic         exp_exhausted;
        logic [7:0]   exp_nonce;
        logic [8:0]   exp_attempts;
    } vec_t;

    vec_t vecs [6];

    task automatic wait_msg(input logic [7:0] nn, input logic need_done);
        int n = 0;
        while (!(sha_enable && sha_message[7:0] == nn && (!need_done || sha_done)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_bound", n < 2000, 1);
    endtask

    initial begin
        logic         f, e;
        logic [7:0]   rn;
        logic [8:0]   ra;
        logic [255:0] rh, t;
        logic [15:0]  p;

        vecs[0] = '{16'hABCD, 256'h1, 3, -1, 1'b1, 1'b0, 8'h03, 9'd4};
        vecs[1] = '{16'h1234, 256'h0, -1, -1, 1'b0, 1'b1, 8'h00, 9'd256};
        vecs[2] = '{16'h0F0F, {4'h8, 248'h123}, 1, 0, 1'b1, 1'b0, 8'h01, 9'd2};
        vecs[3] = '{16'hFFFF, ALL1, 255, -1, 1'b1, 1'b0, 8'hFF, 9'd256};
        vecs[4] = '{16'h0000, 256'h5, 0, -1, 1'b1, 1'b0, 8'h00, 9'd1};
        vecs[5] = '{16'h5A5A, 256'h100, 200, 199, 1'b1, 1'b0, 8'hC8, 9'd201};

        for (int i = 0; i < 256; i++) hash_tab[i] = ALL1;
        rst = 1'b1; start = 1'b0; abort = 1'b0; prefix = '0; target = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_enable", sha_enable, 0);
        check("rst_msg", sha_message, 0);
        check("rst_flags", {found, exhausted, timeout_err}, 0);
        check("rst_attempts", attempts, 0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 256; i++) hash_tab[i] = ALL1;
            if (vecs[v].eq_at >= 0)  hash_tab[vecs[v].eq_at]  = vecs[v].target;
            if (vecs[v].hit_at >= 0) hash_tab[vecs[v].hit_at] = vecs[v].target - 256'd1;
            run_search(vecs[v].prefix, vecs[v].target, vecs[v].exp_found, vecs[v].exp_exhausted,
                       vecs[v].exp_nonce, vecs[v].exp_attempts,
                       vecs[v].exp_found ? vecs[v].target - 256'd1 : 256'd0);
        end

        // reset while a hash of nonce 5 is in flight
        for (int i = 0; i < 256; i++) hash_tab[i] = ALL1;
        pulse_start(16'h2222, 256'h10);
        wait_msg(8'h05, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_enable", sha_enable, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        check("midrst_msg", sha_message, 0);
        check("midrst_attempts", attempts, 0);
        check("midrst_results", {found, exhausted, result_nonce}, 0);
        check("midrst_hash", result_hash, 0);
        rst = 1'b0;
        @(negedge clk);

        // abort coinciding with done at nonce 2 discards that hash
        pulse_start(16'h3333, 256'h10);
        wait_msg(8'h02, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_enable", sha_enable, 0);
        check("abort_flags", {found, exhausted}, 0);
        check("abort_attempts", attempts, 2);
        @(negedge clk);
        check("abort_idle", busy, 0);
        pulse_start(16'h3333, 256'h10);
        check("restart_msg", sha_message, 24'h333300);
        check("restart_attempts", attempts, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_launch", busy, 0);

        // stalled core
        core_stall = 1'b1;
        pulse_start(16'h4444, 256'h10);
`ifdef SHA_TIMEOUT_EN
        repeat (16) @(negedge clk);
        check("wd_before", {timeout_err, busy}, 2'b01);
        @(negedge clk);
        check("wd_fired", {timeout_err, busy, sha_enable}, 3'b100);
        check("wd_flags", {found, exhausted}, 0);
        pulse_start(16'h4444, 256'h10);
        check("wd_clear", timeout_err, 0);
`else
        repeat (40) @(negedge clk);
        check("stall_busy", {busy, sha_enable, timeout_err}, 3'b110);
`endif
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("stall_abort", busy, 0);
        core_stall = 1'b0;
        @(negedge clk);

        // randomized searches against the reference scan
        for (int r = 0; r < 4; r++) begin
            t = rand256();
            t[255:248] = 8'h00;
            for (int i = 0; i < 256; i++) begin
                hash_tab[i] = rand256();
                if ($urandom_range(0, 99) < 3) hash_tab[i] = t - 256'($urandom_range(0, 1));
            end
            p = 16'($urandom());
            ref_search(t, f, e, rn, ra, rh);
            run_search(p, t, f, e, rn, ra, rh);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
